exu_wb_arb: RTL and testbench



---
 rtl/exu_wb_arb_pkg.sv | 14 +
 rtl/exu_wb_arb_wb_fifo.sv | 92 +++++++++
 rtl/exu_wb_arb.sv | 124 ++++++++++++
 tb/tb_exu_wb_arb.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/exu_wb_arb_pkg.sv
// Shared types and constants for the EXU writeback arbiter.
package exu_wb_arb_pkg;

    localparam int WB_XLEN  = 32;
    localparam int NUM_REGS = 32;
    localparam int RD_W     = 5;

    typedef struct packed {
        logic [WB_XLEN-1:0] data;
        logic [RD_W-1:0]    rd_addr;
        logic               kill;
    } wb_req_t;

endpackage

// File: rtl/exu_wb_arb_wb_fifo.sv
// Small LSU load-return FIFO. Each entry carries a kill bit that is set when a
// younger ALU write targets the same rd.
module wb_fifo
    import exu_wb_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_push,
    input  wb_req_t         i_push_req,
    input  logic            i_pop,
    input  logic            i_kill_vld,
    input  logic [RD_W-1:0] i_kill_rd,
    output wb_req_t         o_head,
    output logic            o_full,
    output logic            o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WB_XLEN-1:0] r_data [DEPTH];
    logic [RD_W-1:0]    r_rd   [DEPTH];
    logic [DEPTH-1:0]   r_kill;
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;

    logic [AW-1:0]      w_wr_idx;
    logic [AW-1:0]      w_rd_idx;
    logic [PW-1:0]      w_count;
    logic [AW-1:0]      w_off [DEPTH];
    logic [DEPTH-1:0]   w_valid;
    logic [DEPTH-1:0]   w_kill_hit;
    logic               w_do_push;
    logic               w_do_pop;
    logic               w_push_killed;

    assign w_wr_idx  = r_wr_ptr[AW-1:0];
    assign w_rd_idx  = r_rd_ptr[AW-1:0];
    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (w_wr_idx == w_rd_idx);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // An entry arriving in the same cycle as a matching ALU write is born killed.
    assign w_push_killed = i_push_req.kill | (i_kill_vld && (i_push_req.rd_addr == i_kill_rd));

    always_comb begin
        w_valid    = '0;
        w_kill_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off[i]      = AW'(i) - w_rd_idx;
            w_valid[i]    = ({1'b0, w_off[i]} < w_count);
            w_kill_hit[i] = i_kill_vld && w_valid[i] && (r_rd[i] == i_kill_rd);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_kill   <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            for (int i = 0; i < DEPTH; i++) begin
                if (w_do_push && (w_wr_idx == AW'(i))) begin
                    r_kill[i] <= w_push_killed;
                end else if (w_kill_hit[i]) begin
                    r_kill[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_data[w_wr_idx] <= i_push_req.data;
            r_rd[w_wr_idx]   <= i_push_req.rd_addr;
        end
    end

    always_comb begin
        o_head         = '0;
        o_head.data    = r_data[w_rd_idx];
        o_head.rd_addr = r_rd[w_rd_idx];
        o_head.kill    = r_kill[w_rd_idx];
    end

endmodule

// File: rtl/exu_wb_arb.sv
// Writeback arbiter: ALU results have fixed priority over buffered LSU returns
// into the single register-file write port; tracks pending loads and retires.
module exu_wb_arb
    import exu_wb_arb_pkg::*;
#(
    parameter int XLEN      = WB_XLEN,
    parameter int LSU_DEPTH = 2,
    parameter int CNT_W     = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  alu_wb_data,
    input  logic [4:0]       alu_wb_rd_addr,
    input  logic             alu_wb_rd_wr_en,
    input  logic             lsu_wb_vld,
    output logic             lsu_wb_rdy,
    input  logic [XLEN-1:0]  lsu_wb_data,
    input  logic [4:0]       lsu_wb_rd_addr,
    input  logic             lsu_issue,
    input  logic [4:0]       lsu_issue_rd,
    output logic             rf_wr_en,
    output logic [4:0]       rf_wr_addr,
    output logic [XLEN-1:0]  rf_wr_data,
    output logic [31:0]      rd_busy,
    output logic [CNT_W-1:0] retire_cnt
);

    logic                r_rf_wr_en;
    logic [4:0]          r_rf_wr_addr;
    logic [XLEN-1:0]     r_rf_wr_data;
    logic [NUM_REGS-1:0] r_rd_busy;
    logic [CNT_W-1:0]    r_retire_cnt;

    logic                w_alu_win;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    wb_req_t             w_push_req;
    wb_req_t             w_head;
    logic                w_wr_en_nxt;
    logic [4:0]          w_wr_addr_nxt;
    logic [XLEN-1:0]     w_wr_data_nxt;
    logic [NUM_REGS-1:0] w_busy_set;
    logic [NUM_REGS-1:0] w_busy_clr;
    logic [NUM_REGS-1:0] w_busy_nxt;

    assign w_alu_win  = alu_wb_rd_wr_en && (alu_wb_rd_addr != 5'd0);
    assign lsu_wb_rdy = ~w_full;
    assign w_push     = lsu_wb_vld & ~w_full;
    // Pop decision uses pre-push state, so a just-pushed entry never bypasses.
    assign w_pop      = ~w_alu_win & ~w_empty;

    always_comb begin
        w_push_req         = '0;
        w_push_req.data    = lsu_wb_data;
        w_push_req.rd_addr = lsu_wb_rd_addr;
        w_push_req.kill    = 1'b0;
    end

    wb_fifo #(
        .DEPTH (LSU_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_req (w_push_req),
        .i_pop      (w_pop),
        .i_kill_vld (w_alu_win),
        .i_kill_rd  (alu_wb_rd_addr),
        .o_head     (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    always_comb begin
        w_wr_en_nxt   = 1'b0;
        w_wr_addr_nxt = r_rf_wr_addr;
        w_wr_data_nxt = r_rf_wr_data;
        if (w_alu_win) begin
            w_wr_en_nxt   = 1'b1;
            w_wr_addr_nxt = alu_wb_rd_addr;
            w_wr_data_nxt = alu_wb_data;
        end else if (w_pop) begin
            w_wr_en_nxt   = ~w_head.kill && (w_head.rd_addr != 5'd0);
            w_wr_addr_nxt = w_head.rd_addr;
            w_wr_data_nxt = w_head.data;
        end
    end

    // Issue of a new load wins over a same-cycle writeback of the same rd.
    always_comb begin
        w_busy_set = '0;
        w_busy_clr = '0;
        if (lsu_issue) w_busy_set[lsu_issue_rd]   = 1'b1;
        if (w_alu_win) w_busy_clr[alu_wb_rd_addr] = 1'b1;
        if (w_pop)     w_busy_clr[w_head.rd_addr] = 1'b1;
        w_busy_nxt    = (r_rd_busy & ~w_busy_clr) | w_busy_set;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rf_wr_en   <= 1'b0;
            r_rf_wr_addr <= '0;
            r_rf_wr_data <= '0;
            r_rd_busy    <= '0;
            r_retire_cnt <= '0;
        end else begin
            r_rf_wr_en   <= w_wr_en_nxt;
            r_rf_wr_addr <= w_wr_addr_nxt;
            r_rf_wr_data <= w_wr_data_nxt;
            r_rd_busy    <= w_busy_nxt;
            r_retire_cnt <= r_retire_cnt + CNT_W'(w_wr_en_nxt);
        end
    end

    assign rf_wr_en   = r_rf_wr_en;
    assign rf_wr_addr = r_rf_wr_addr;
    assign rf_wr_data = r_rf_wr_data;
    assign rd_busy    = r_rd_busy;
    assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_exu_wb_arb.sv
// Randomized and directed bench for exu_wb_arb against a queue-based model.
module tb_exu_wb_arb;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] alu_wb_data = '0;
    logic [4:0]  alu_wb_rd_addr = '0;
    logic        alu_wb_rd_wr_en = 1'b0;
    logic        lsu_wb_vld = 1'b0;
    logic        lsu_wb_rdy;
    logic [31:0] lsu_wb_data = '0;
    logic [4:0]  lsu_wb_rd_addr = '0;
    logic        lsu_issue = 1'b0;
    logic [4:0]  lsu_issue_rd = '0;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic [31:0] rd_busy;
    logic [63:0] retire_cnt;

    exu_wb_arb #(.XLEN(32), .LSU_DEPTH(DEPTH), .CNT_W(64)) dut (
        .clk             (clk),
        .rst             (rst),
        .alu_wb_data     (alu_wb_data),
        .alu_wb_rd_addr  (alu_wb_rd_addr),
        .alu_wb_rd_wr_en (alu_wb_rd_wr_en),
        .lsu_wb_vld      (lsu_wb_vld),
        .lsu_wb_rdy      (lsu_wb_rdy),
        .lsu_wb_data     (lsu_wb_data),
        .lsu_wb_rd_addr  (lsu_wb_rd_addr),
        .lsu_issue       (lsu_issue),
        .lsu_issue_rd    (lsu_issue_rd),
        .rf_wr_en        (rf_wr_en),
        .rf_wr_addr      (rf_wr_addr),
        .rf_wr_data      (rf_wr_data),
        .rd_busy         (rd_busy),
        .retire_cnt      (retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        bit          kill;
    } ment_t;

    ment_t       q[$];
    logic [31:0] m_busy = '0;
    logic [63:0] m_cnt  = '0;
    logic        m_en   = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    logic [31:0] dut_rf [32];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge of the architectural rules, using the inputs held across it.
    task automatic model_step();
        bit    alu_w;
        bit    do_push;
        ment_t e;
        alu_w   = alu_wb_rd_wr_en && (alu_wb_rd_addr != 0);
        do_push = lsu_wb_vld && (q.size() < DEPTH);
        m_en    = 1'b0;
        if (alu_w) begin
            foreach (q[i]) if (q[i].rd == alu_wb_rd_addr) q[i].kill = 1'b1;
            m_en   = 1'b1;
            m_addr = alu_wb_rd_addr;
            m_data = alu_wb_data;
            m_busy[alu_wb_rd_addr] = 1'b0;
        end else if (q.size() > 0) begin
            e = q.pop_front();
            m_busy[e.rd] = 1'b0;
            if (!e.kill && e.rd != 0) begin
                m_en   = 1'b1;
                m_addr = e.rd;
                m_data = e.data;
            end
        end
        if (lsu_issue) m_busy[lsu_issue_rd] = 1'b1;
        m_busy[0] = 1'b0;
        if (do_push) q.push_back('{data: lsu_wb_data, rd: lsu_wb_rd_addr,
                                   kill: alu_w && (lsu_wb_rd_addr == alu_wb_rd_addr)});
        m_cnt = m_cnt + 64'(m_en);
    endtask

    task automatic cyc(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                       input bit lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input bit iv, input logic [4:0] ird, output bit acc);
        @(negedge clk);
        alu_wb_rd_wr_en = av;  alu_wb_rd_addr = ard;  alu_wb_data = ad;
        lsu_wb_vld      = lv;  lsu_wb_rd_addr = lrd;  lsu_wb_data = ld;
        lsu_issue       = iv;  lsu_issue_rd   = ird;
        #1;
        check("rdy", 64'(lsu_wb_rdy), 64'(q.size() < DEPTH));
        acc = lv && lsu_wb_rdy;
        @(posedge clk);
        #1;
        model_step();
        check("wr_en", 64'(rf_wr_en), 64'(m_en));
        if (m_en) begin
            check("wr_addr", 64'(rf_wr_addr), 64'(m_addr));
            check("wr_data", 64'(rf_wr_data), 64'(m_data));
        end
        check("busy", 64'(rd_busy), 64'(m_busy));
        check("cnt", retire_cnt, m_cnt);
        if (rf_wr_en) dut_rf[rf_wr_addr] = rf_wr_data;
    endtask

    task automatic idle();
        bit a;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, a);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_en"},   64'(rf_wr_en),   64'd0);
        check({tag, "_addr"}, 64'(rf_wr_addr), 64'd0);
        check({tag, "_data"}, 64'(rf_wr_data), 64'd0);
        check({tag, "_busy"}, 64'(rd_busy),    64'd0);
        check({tag, "_cnt"},  retire_cnt,      64'd0);
        check({tag, "_rdy"},  64'(lsu_wb_rdy), 64'd1);
    endtask

    initial begin
        bit acc;
        int li;
        int alu_pct;
        for (int i = 0; i < 32; i++) dut_rf[i] = '0;

        // Power-on reset
        repeat (2) @(negedge clk);
        check_reset_state("por");
        rst = 1'b0;

        // ALU only
        cyc(1, 5, 32'h1234, 0, 0, 0, 0, 0, acc);
        check("alu5_data", 64'(rf_wr_data), 64'h1234);
        check("alu5_cnt", retire_cnt, 64'd1);
        cyc(1, 0, 32'h5555, 0, 0, 0, 0, 0, acc);
        check("alu0_en", 64'(rf_wr_en), 64'd0);

        // LSU only
        cyc(0, 0, 0, 0, 0, 0, 1, 7, acc);
        check("busy7_set", 64'(rd_busy[7]), 64'd1);
        cyc(0, 0, 0, 1, 7, 32'hDEAD, 0, 0, acc);
        check("busy7_held", 64'(rd_busy[7]), 64'd1);
        idle();
        check("lsu7_data", 64'(rf_wr_data), 64'hDEAD);
        check("busy7_clr", 64'(rd_busy[7]), 64'd0);

        // Contention: ALU busy for 4 cycles while three loads are offered
        li = 0;
        for (int c = 0; c < 10; c++) begin
            cyc(c < 4, 5'(c + 1), 32'h100 + c, li < 3, 5'(10 + li), 32'hC000 + li, 0, 0, acc);
            if (acc) li++;
        end
        check("loads_accepted", 64'(li), 64'd3);

        // WAW kill
        cyc(1, 1, 32'h1, 1, 9, 32'hAAAA, 0, 0, acc);
        cyc(1, 9, 32'hBBBB, 0, 0, 0, 0, 0, acc);
        idle();
        check("waw_pop_en", 64'(rf_wr_en), 64'd0);
        idle();
        check("waw_reg9", 64'(dut_rf[9]), 64'hBBBB);

        // Pointer wrap
        for (int k = 0; k < 10; k++) begin
            cyc(0, 0, 0, 1, 5'((k % 7) + 1), 32'h5000 + k * 32'h111, 0, 0, acc);
            idle();
        end

        // Randomized phases with varying ALU pressure
        for (int ph = 0; ph < 4; ph++) begin
            alu_pct = (ph == 0) ? 10 : (ph == 1) ? 50 : (ph == 2) ? 90 : 30;
            for (int c = 0; c < 100; c++) begin
                cyc($urandom_range(0, 99) < alu_pct, 5'($urandom_range(0, 7)), $urandom,
                    $urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom,
                    $urandom_range(0, 99) < 30, 5'($urandom_range(0, 7)), acc);
            end
        end

        // Asynchronous reset while the FIFO is full
        cyc(1, 2, 32'h22, 1, 3, 32'h33, 1, 3, acc);
        cyc(1, 2, 32'h22, 1, 4, 32'h44, 1, 4, acc);
        cyc(1, 2, 32'h22, 1, 5, 32'h55, 0, 0, acc);
        check("pre_rst_rdy", 64'(lsu_wb_rdy), 64'd0);
        @(negedge clk);
        alu_wb_rd_wr_en = 0; lsu_wb_vld = 0; lsu_issue = 0;
        #2 rst = 1'b1;
        #1;
        check_reset_state("arst");
        q.delete();
        m_busy = '0; m_cnt = '0; m_en = 1'b0; m_addr = '0; m_data = '0;
        @(negedge clk);
        rst = 1'b0;
        idle();
        check("post_rst_en", 64'(rf_wr_en), 64'd0);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
